uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal word FIFO.
// Data width, parity mode and stop-bit count are fixed at elaboration. Queued words are sent
// back-to-back, with no idle gap between frames.
//
// Ports:
//   i_Clk         system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_data        word to queue
//   i_valid       i_data valid; accepted when o_ready is high at the clock edge
//   o_ready       FIFO not full
//   o_tx_serial   serial line, idles high
//   o_tx_done     one-cycle pulse during the last cycle of each frame's final stop bit
//   o_busy        a frame is on the line
//   o_fifo_count  number of queued words
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          i_Clk,
  input  logic                          i_reset,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx_serial,
  output logic                          o_tx_done,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD_RATE;
  localparam int unsigned BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);
  localparam logic [PtrW:0]    CountFull = (PtrW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 full, push, pop;
  logic [DATA_BITS-1:0] head;

  assign full         = (count_q == CountFull);
  assign o_ready      = ~full;
  assign push         = i_valid & ~full;
  assign head         = mem_q[rd_ptr_q];
  assign o_fifo_count = count_q;

  // Storage needs no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [3:0]           idx_q, idx_d;     // data-bit index in StData, stop-bit index in StStop
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;
  logic                 load;
  logic                 head_par;

  // Even mode: parity = XOR of data, so the total count of ones is even; odd mode inverts it.
  assign head_par = (PARITY == 1) ? ~^head : ^head;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    load    = 1'b0;
    bit_end = (baud_q == BaudLast);

    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + BaudW'(1);
    end

    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (count_q != '0) load = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == DataLast) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == StopLast) begin
            // Chain straight into the next start bit when more words are queued.
            if (count_q != '0) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      par_d   = head_par;
      state_d = StStart;
      tx_d    = 1'b0;
      baud_d  = '0;
      idx_d   = '0;
    end

    busy_d = (state_d != StIdle);
    // Registered pulse: assert when the next cycle is the final cycle of the final stop bit.
    done_d = (state_d == StStop) && (baud_d == BaudLast) && (idx_d == StopLast);
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_serial = tx_q;
  assign o_busy      = busy_q;
  assign o_tx_done   = done_q;

endmodule
